// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the rotating-priority router output arbiter.
// Port-index constants name the inputs of the 5-port mesh router.
package arbiter_pkg;

  localparam int MAX_PORTS = 16;

  localparam int P_L = 0;
  localparam int P_N = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_S = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Width of a port index; never below 1 so a 2-port arbiter still has a bit.
  function automatic int port_idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [MAX_PORTS-1:0] onehot(input logic [3:0] idx);
    logic [MAX_PORTS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of vec scanning start, start+1, ...
// modulo N. Purely combinational.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int N = 5,
  parameter int W = port_idx_w(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W:0]   pos;
  logic [W-1:0] p;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    p     = '0;
    for (int i = 0; i < N; i++) begin
      // Wrap explicitly so non-power-of-2 N stays inside 0..N-1.
      pos = {1'b0, start} + (W+1)'(i);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      p = pos[W-1:0];
      if (!found && vec[p]) begin
        found = 1'b1;
        idx   = p;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr_param.sv
// Router output arbiter: NUM_PORTS requesters onto one crossbar output with the
// RTS/DCTS handshake, rotating or sticky priority and optional packet lock.
module arbiter_rr_param
  import arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 5,
  parameter bit STICKY    = 1'b1,
  parameter bit LOCK      = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] tail,
  input  logic                 dcts,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] xbar_sel,
  output logic                 rts
);

  localparam int PORT_IDX_W = port_idx_w(NUM_PORTS);
  localparam logic [PORT_IDX_W-1:0] LAST_IDX = PORT_IDX_W'(NUM_PORTS - 1);

  // Handshake: a flit moves on an edge where rts=1 and dcts=1; grant marks
  // that cycle combinationally, and rts drops for one cycle afterwards.

  arb_state_e            state_q, state_d;
  logic [PORT_IDX_W-1:0] cur_q, cur_d;
  logic [PORT_IDX_W-1:0] last_q, last_d;
  logic                  rts_q, rts_d;

  logic [PORT_IDX_W-1:0] pick_start;
  logic [PORT_IDX_W-1:0] pick_idx;
  logic                  pick_found;
  logic [NUM_PORTS-1:0]  cur_onehot;

  function automatic logic [PORT_IDX_W-1:0] wrap_inc(input logic [PORT_IDX_W-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  always_comb begin
    pick_start = wrap_inc(last_q);
    if (state_q == ST_BUSY) begin
      if (STICKY) pick_start = cur_q;
      else        pick_start = wrap_inc(cur_q);
    end
  end

  rr_pick #(
    .N (NUM_PORTS),
    .W (PORT_IDX_W)
  ) u_pick (
    .vec   (req),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    rts_d   = rts_q;
    if (state_q == ST_IDLE) begin
      if (|req) begin
        state_d = ST_BUSY;
        cur_d   = pick_idx;
        rts_d   = 1'b1;
      end
    end else if (!rts_q) begin
      rts_d = 1'b1;
    end else if (dcts) begin
      last_d = cur_q;
      rts_d  = 1'b0;
      // Mid-packet under lock the holder keeps the output whatever req says.
      if (!(LOCK && !tail[cur_q])) begin
        if (pick_found) cur_d   = pick_idx;
        else            state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      last_q  <= LAST_IDX;
      rts_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      rts_q   <= rts_d;
    end
  end

  assign cur_onehot = NUM_PORTS'(onehot(4'(cur_q)));
  assign xbar_sel   = (state_q == ST_BUSY) ? cur_onehot : '0;
  assign grant      = xbar_sel & {NUM_PORTS{rts_q & dcts}};
  assign rts        = rts_q;

endmodule
